uart_rx_module: RTL

//  Asynchronous UART receiver: 8N1 frames on rx -> bytes on valid/ready handshake.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_reader.sv | 112 +++++++++++
 rtl/uart_rx_module.sv | 72 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and bit-timing helper for the UART receiver
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Clock cycles per line bit.
  function automatic int uart_scale(input int clk_mhz, input int boadrate);
    return (clk_mhz * 1_000_000) / boadrate;
  endfunction

endpackage

// File: rtl/uart_rx_reader.sv
// rtl/uart_rx_reader.sv - line synchronizer, bit timer, frame FSM and shift register
// UART_RX_PARITY_EN selects 8E1 framing with a parity_err output; default is 8N1.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int boadrate = 9600
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx,
  output logic                   byte_vld,
  output logic [UART_DATA_W-1:0] byte_data,
  output logic                   frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam int SCALE = uart_scale(clk_mhz, boadrate);
  localparam int CNT_W = $clog2(SCALE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCALE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SCALE - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BREAK  = BREAK;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
  logic par_bad;
`endif

  logic                   rx_m;
  logic                   rx_s;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (state != S_IDLE && state != S_BREAK)
        cnt <= tick ? CNT_FULL : cnt - 1'b1;
      case (state)
        S_IDLE:
          if (!rx_s) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        S_START:
          if (tick) begin
            if (rx_s) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
        S_DATA:
          if (tick) begin
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        S_PARITY:
          if (tick) begin
            par_bad <= (rx_s != ^shreg);
            state   <= S_STOP;
          end
`endif
        S_STOP:
          if (tick) state <= rx_s ? S_IDLE : S_BREAK;
        // A held-low line must return high before a new start edge is accepted.
        S_BREAK:
          if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign byte_data = shreg;
  assign frame_err = (state == S_STOP) && tick && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign byte_vld   = (state == S_STOP) && tick && rx_s && !par_bad;
  assign parity_err = (state == S_PARITY) && tick && (rx_s != ^shreg);
`else
  assign byte_vld   = (state == S_STOP) && tick && rx_s;
`endif

endmodule

// File: rtl/uart_rx_module.sv
// rtl/uart_rx_module.sv - UART receiver top: reader plus one-entry holding register
// UART_RX_PARITY_EN adds 8E1 framing and the parity_err pulse output.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int boadrate = 9600
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx,
  output logic                   valid,
  output logic [UART_DATA_W-1:0] data,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  logic                   byte_vld;
  logic                   rd_frame_err;
  logic [UART_DATA_W-1:0] byte_data;
`ifdef UART_RX_PARITY_EN
  logic                   rd_parity_err;
`endif

  uart_rx_reader #(
    .clk_mhz (clk_mhz),
    .boadrate(boadrate)
  ) u_reader (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .frame_err (rd_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(rd_parity_err)
`endif
  );

  // A new byte may replace the held one only if the consumer takes it this clock.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= rd_frame_err;
      overrun   <= byte_vld && valid && !ready;
      if (byte_vld && (!valid || ready)) begin
        data  <= byte_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) parity_err <= 1'b0;
    else       parity_err <= rd_parity_err;
  end
`endif

endmodule
